// File: rtl/lz77_pkg.sv
// Shared definitions for the LZ77 stream encoder and the downstream token packer.
//   DEF_*      default parameter values for the encoder
//   off_w()    offset field width for a given dictionary depth
//   len_w()    length field width for a given maximum match
//   lz77_token_t  packed token {offset, length, symbol, last} at default widths
package lz77_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DICT_DEPTH = 32;
    localparam int DEF_MAX_MATCH  = 18;

    // Offsets run 1..DICT_DEPTH with 0 meaning "no match".
    function automatic int off_w(input int dict_depth);
        return $clog2(dict_depth + 1);
    endfunction

    // Lengths run 0..MAX_MATCH.
    function automatic int len_w(input int max_match);
        return $clog2(max_match + 1);
    endfunction

    typedef struct packed {
        logic [off_w(DEF_DICT_DEPTH)-1:0] offset;
        logic [len_w(DEF_MAX_MATCH)-1:0]  length;
        logic [DEF_DATA_WIDTH-1:0]        symbol;
        logic                             last;
    } lz77_token_t;

endpackage

// File: rtl/lz77_stream_encoder_if.sv
// Symbol-in / token-out stream bundle for the LZ77 encoder.
//   in_valid/in_ready/in_data/in_last        symbol stream into the encoder
//   out_valid/out_ready/out_offset/
//   out_length/out_symbol/out_last           token stream out of the encoder
// master: the surrounding system (drives symbols, accepts tokens)
// slave : the encoder
interface lz77_stream_encoder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int OFF_W      = 6,
    parameter int LEN_W      = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [OFF_W-1:0]      out_offset;
    logic [LEN_W-1:0]      out_length;
    logic [DATA_WIDTH-1:0] out_symbol;
    logic                  out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_offset, out_length, out_symbol, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_offset, out_length, out_symbol, out_last
    );
endinterface

// File: rtl/lz77_prio_enc.sv
// Lowest-set-index encoder over a distance vector indexed 1..DICT_DEPTH.
//   vec  candidate distance vector, bit d marks distance d
//   idx  smallest set distance, 0 when vec is empty
module lz77_prio_enc
    import lz77_pkg::*;
#(
    parameter int DICT_DEPTH = DEF_DICT_DEPTH,
    parameter int OFF_W      = off_w(DICT_DEPTH)
) (
    input  logic [DICT_DEPTH:1] vec,
    output logic [OFF_W-1:0]    idx
);
    // Scan downwards so the last hit written is the smallest distance.
    always_comb begin
        idx = '0;
        for (int unsigned d = DICT_DEPTH; d >= 1; d--) begin
            if (vec[d]) idx = OFF_W'(d);
        end
    end
endmodule

// File: rtl/lz77_stream_encoder.sv
// Byte-serial LZ77 encoder: one symbol per cycle in, (offset, length, symbol)
// tokens out with backpressure, explicit end-of-stream and saturating matches.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   stream bundle (slave side): symbols in, tokens out
//   busy  a match is in progress or a token is waiting to be taken
module lz77_stream_encoder
    import lz77_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DICT_DEPTH = DEF_DICT_DEPTH,
    parameter int MAX_MATCH  = DEF_MAX_MATCH,
    parameter int OFF_W      = off_w(DICT_DEPTH),
    parameter int LEN_W      = len_w(MAX_MATCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    lz77_stream_encoder_if.slave bus,
    output logic                 busy
);
    logic [DATA_WIDTH-1:0] dict [DICT_DEPTH];
    logic [OFF_W-1:0]      fill;
    logic [LEN_W-1:0]      len;
    logic [DICT_DEPTH:1]   act;
    logic [DICT_DEPTH:1]   eq;
    logic [DICT_DEPTH:1]   cand;
    logic [OFF_W-1:0]      best_off;
    logic                  accept;
    logic                  terminate;

    logic                  tok_valid;
    logic [OFF_W-1:0]      tok_offset;
    logic [LEN_W-1:0]      tok_length;
    logic [DATA_WIDTH-1:0] tok_symbol;
    logic                  tok_last;

    assign bus.in_ready   = !tok_valid || bus.out_ready;
    assign bus.out_valid  = tok_valid;
    assign bus.out_offset = tok_offset;
    assign bus.out_length = tok_length;
    assign bus.out_symbol = tok_symbol;
    assign bus.out_last   = tok_last;
    assign busy           = (len != '0) || tok_valid;

    assign accept = bus.in_valid && bus.in_ready;

    // Distances beyond the filled part of the window hold stale data and are masked.
    always_comb begin
        eq = '0;
        for (int unsigned d = 1; d <= DICT_DEPTH; d++) begin
            eq[d] = (dict[d-1] == bus.in_data) && (OFF_W'(d) <= fill);
        end
        cand      = (len == '0) ? eq : (act & eq);
        terminate = (cand == '0) || (len == LEN_W'(MAX_MATCH)) || bus.in_last;
    end

    // Offset is taken from the candidates that survived up to the previous symbol.
    lz77_prio_enc #(
        .DICT_DEPTH (DICT_DEPTH),
        .OFF_W      (OFF_W)
    ) u_prio (
        .vec (act),
        .idx (best_off)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            dict[0] <= bus.in_data;
            for (int unsigned i = 1; i < DICT_DEPTH; i++) begin
                dict[i] <= dict[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill       <= '0;
            len        <= '0;
            act        <= '0;
            tok_valid  <= 1'b0;
            tok_offset <= '0;
            tok_length <= '0;
            tok_symbol <= '0;
            tok_last   <= 1'b0;
        end else begin
            if (bus.out_ready) tok_valid <= 1'b0;
            if (accept) begin
                if (bus.in_last)
                    fill <= '0;
                else if (fill != OFF_W'(DICT_DEPTH))
                    fill <= fill + OFF_W'(1);

                if (terminate) begin
                    tok_valid  <= 1'b1;
                    tok_offset <= best_off;
                    tok_length <= len;
                    tok_symbol <= bus.in_data;
                    tok_last   <= bus.in_last;
                    act        <= '0;
                    len        <= '0;
                end else begin
                    act <= cand;
                    len <= len + LEN_W'(1);
                end
            end
        end
    end
endmodule

// File: doc/lz77_stream_encoder.md
Name: lz77_stream_encoder

Overview:
- Parametrised, byte-serial LZ77 encoder; successor to the fixed-size lz77_encoder.
- Accepts one symbol per cycle on a valid/ready stream and emits (offset, length, next_symbol) triples on a valid/ready token stream with backpressure.
- Adds explicit end-of-stream handling, a saturating MAX_MATCH and a fill-masked sliding dictionary.
- Sits between the input byte FIFO and the Huffman/token packer in the GZIP path.

Parameters:
- DATA_WIDTH, 8, symbol width.
- DICT_DEPTH, 32, sliding-window depth in symbols (>=2).
- MAX_MATCH, 18, maximum encoded match length (>=1).
- OFF_W, $clog2(DICT_DEPTH+1), offset field width (derived).
- LEN_W, $clog2(MAX_MATCH+1), length field width (derived).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input symbol valid.
- in_ready  out  1  encoder can accept a symbol.
- in_data  in  DATA_WIDTH  input symbol.
- in_last  in  1  symbol is the final one of the stream.
- out_valid  out  1  token valid.
- out_ready  in  1  downstream accepts token.
- out_offset  out  OFF_W  match distance 1..DICT_DEPTH; 0 when no match.
- out_length  out  LEN_W  match length 0..MAX_MATCH.
- out_symbol  out  DATA_WIDTH  literal terminating the token.
- out_last  out  1  token closes the stream.
- busy  out  1  match in progress or token pending.

Behaviour:
- Reset (async, immediate): out_valid=0, out_offset=0, out_length=0, out_symbol=0, out_last=0, busy=0, fill=0, len=0, act=0. Dictionary contents don't-care.
- Handshakes:
  - in_ready = !out_valid || out_ready. A symbol is accepted when in_valid && in_ready.
  - A token is consumed when out_valid && out_ready.
  - Token outputs stay stable while out_valid && !out_ready.
- Dictionary:
  - dict[0] is the most recent symbol. Every accepted symbol shifts in at dict[0].
  - fill counts symbols held and saturates at DICT_DEPTH.
- Active vector: act[d], d=1..DICT_DEPTH, marks live candidate distances.
- Per accepted symbol b, evaluated against dict before the shift:
  - eq[d] = (dict[d-1]==b) && (d<=fill).
  - cand = (len==0) ? eq : (act & eq).
- Decision on the same edge as acceptance:
  - Terminate (token issued) if cand==0, or len==MAX_MATCH, or in_last.
  - Otherwise extend: act<=cand, len<=len+1, no token.
- Token on terminate:
  - out_offset = smallest set d in act (0 if len==0); out_length = len; out_symbol = b; out_last = in_last.
  - Then act<=0, len<=0.
  - The terminating symbol is never counted in out_length, even when it would have matched.
- Latency: token valid on the cycle after the terminating symbol is accepted.
- Throughput: one symbol per cycle while out_ready is high.
- Stream end: on an accepted in_last, fill<=0 after the shift, so the next stream starts with an empty window.
- Offset tie-break: the smallest distance wins. Overlapping matches (distance < length) are legal.
- busy = (len!=0) || out_valid.
- Simultaneous token consume and new symbol in the same cycle: both take effect with no bubble.
- in_data and in_last are ignored when in_valid is low.

Decomposition:
- lz77_pkg holds:
  - default parameter constants;
  - OFF_W/LEN_W derivation functions;
  - the packed token struct {offset, length, symbol, last}, shared with the packer.
- Sub-module lz77_prio_enc: parametrised DICT_DEPTH-bit lowest-set-index encoder returning an OFF_W distance (0 when the vector is empty).

Test Plan:
- 16×'a' then '$' with in_last, defaults -> tokens (0,0,'a'), (1,15,'$' last=1); no other tokens.
- "aacaacab..." -> first three tokens (0,0,'a'), (1,1,'c'), (3,4,'b').
- 24×'a' then '$' last, MAX_MATCH=18 -> (0,0,'a'), (1,18,'a'), (1,4,'$' last=1).
- out_ready held low for 5 cycles while a token is pending -> in_ready=0, token fields stable; on release the token is taken, and a symbol is accepted in the same cycle.
- DICT_DEPTH=4: "abcde" then 'a' last -> 'a' lies at distance 5 > depth, so (0,0,'a' last=1) is emitted; 'a' does not match.
- rst pulsed mid-match (len=3) -> out_valid and busy drop asynchronously; the next 'x' yields (0,0,'x').
